// File: rtl/demux_pkg.sv
// Shared definitions for the two-beat byte demultiplexer: FSM state encoding and default bus width.
package demux_pkg;

  typedef enum logic [1:0] {
    S_HI   = 2'b00,
    S_LO   = 2'b01,
    S_FULL = 2'b10
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/byte_demux_reg_byte_reg.sv
// WIDTH-bit holding register with synchronous active-high reset and load enable.
module byte_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else if (load) begin
      q_q <= d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/byte_demux_reg.sv
// Two-beat deserializer: steers successive accepted beats into hi/lo halves and offers the word with valid/ready.
// Optional even-parity checking over {din, in_par} is enabled by defining DEMUX_PARITY_EN.
module byte_demux_reg
  import demux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] din,
`ifdef DEMUX_PARITY_EN
  input  logic             in_par,
  output logic             par_err,
`endif
  output logic             in_ready,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             out_valid,
  input  logic             out_ready
);

  state_e state_q;
  logic   out_valid_q;
  logic   accept;
  logic   hi_load;
  logic   lo_load;

  // A full word blocks new beats unless it is being taken in the same cycle.
  assign in_ready = ena && ((state_q != S_FULL) || out_ready);
  assign accept   = in_valid && in_ready;
  assign hi_load  = accept && ((state_q == S_HI) || (state_q == S_FULL));
  assign lo_load  = accept && (state_q == S_LO);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_HI;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_HI: begin
          if (accept) state_q <= S_LO;
        end
        S_LO: begin
          if (accept) begin
            state_q     <= S_FULL;
            out_valid_q <= 1'b1;
          end
        end
        S_FULL: begin
          if (out_ready) begin
            state_q     <= accept ? S_LO : S_HI;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_HI;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;

  byte_reg #(.WIDTH(WIDTH)) u_hi_reg (
    .clk  (clk),
    .rst  (rst),
    .load (hi_load),
    .d    (din),
    .q    (hi_out)
  );

  byte_reg #(.WIDTH(WIDTH)) u_lo_reg (
    .clk  (clk),
    .rst  (rst),
    .load (lo_load),
    .d    (din),
    .q    (lo_out)
  );

`ifdef DEMUX_PARITY_EN
  logic err_q;
  logic beat_bad;

  assign beat_bad = ^{din, in_par};

  // First beat restarts the flag; second beat can only add to it.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (hi_load) begin
      err_q <= beat_bad;
    end else if (lo_load) begin
      err_q <= err_q | beat_bad;
    end
  end

  assign par_err = out_valid_q & err_q;
`endif

endmodule

// File: tb/tb_byte_demux_reg.sv
// Directed self-checking bench for byte_demux_reg with hand-computed expectations.
module tb_byte_demux_reg;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         ena;
  logic         in_valid;
  logic [W-1:0] din;
  logic         in_ready;
  logic [W-1:0] hi_out;
  logic [W-1:0] lo_out;
  logic         out_valid;
  logic         out_ready;
`ifdef DEMUX_PARITY_EN
  logic         in_par;
  logic         par_err;
`endif

  int checks;
  int failures;

  byte_demux_reg #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .in_valid  (in_valid),
    .din       (din),
`ifdef DEMUX_PARITY_EN
    .in_par    (in_par),
    .par_err   (par_err),
`endif
    .in_ready  (in_ready),
    .hi_out    (hi_out),
    .lo_out    (lo_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_word(input string tag, input logic [W-1:0] h, input logic [W-1:0] l,
                          input logic v);
    chk({tag, ".hi"}, 32'(hi_out), 32'(h));
    chk({tag, ".lo"}, 32'(lo_out), 32'(l));
    chk({tag, ".ov"}, 32'(out_valid), 32'(v));
  endtask

  logic [W-1:0] stream [6];

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    ena       = 1'b0;
    in_valid  = 1'b0;
    din       = '0;
    out_ready = 1'b0;
`ifdef DEMUX_PARITY_EN
    in_par    = 1'b0;
`endif
    tick();
    tick();
    rst = 1'b0;
    chk_word("reset", 8'h00, 8'h00, 1'b0);
    chk("reset.rdy_ena0", 32'(in_ready), 32'd0);
    ena = 1'b1;
    #1;
    chk("reset.rdy_ena1", 32'(in_ready), 32'd1);

    // Basic assembly with consumer stalled
    in_valid = 1'b1;
    din = 8'hA5;
    tick();
    chk("t1.ov_after_first", 32'(out_valid), 32'd0);
    din = 8'h3C;
    #1;
    chk("t1.rdy_lo", 32'(in_ready), 32'd1);
    tick();
    chk_word("t1.word", 8'hA5, 8'h3C, 1'b1);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_word("t1.hold", 8'hA5, 8'h3C, 1'b1);
    end

    // Stalled consumer blocks new beats, then take + reload in one cycle
    in_valid = 1'b1;
    din = 8'hFF;
    #1;
    chk("t2.rdy_stall", 32'(in_ready), 32'd0);
    tick();
    chk_word("t2.stall", 8'hA5, 8'h3C, 1'b1);
    out_ready = 1'b1;
    din = 8'h11;
    #1;
    chk("t2.rdy_take", 32'(in_ready), 32'd1);
    tick();
    chk_word("t2.reload", 8'h11, 8'h3C, 1'b0);
    out_ready = 1'b0;
    #1;
    chk("t2.rdy_in_lo", 32'(in_ready), 32'd1);
    din = 8'h22;
    tick();
    chk_word("t2.word2", 8'h11, 8'h22, 1'b1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("t2.taken", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Enable gating keeps the partial word
    in_valid = 1'b1;
    din = 8'h0F;
    tick();
    ena = 1'b0;
    din = 8'hF0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t3.rdy_gated", 32'(in_ready), 32'd0);
      tick();
      chk_word("t3.gated", 8'h0F, 8'h22, 1'b0);
    end
    ena = 1'b1;
    tick();
    chk_word("t3.word", 8'h0F, 8'hF0, 1'b1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset mid-word discards the partial word
    in_valid = 1'b1;
    din = 8'h55;
    tick();
    chk("t4.hi_partial", 32'(hi_out), 32'h55);
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    chk_word("t4.reset", 8'h00, 8'h00, 1'b0);
    in_valid = 1'b1;
    din = 8'h01;
    tick();
    din = 8'h02;
    tick();
    chk_word("t4.word", 8'h01, 8'h02, 1'b1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("t4.taken", 32'(out_valid), 32'd0);

    // Back-to-back streaming at one word per two cycles
    stream[0] = 8'h10; stream[1] = 8'h20; stream[2] = 8'h30;
    stream[3] = 8'h40; stream[4] = 8'h50; stream[5] = 8'h60;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      din = stream[i];
      tick();
      if (i % 2 == 1) begin
        chk_word($sformatf("t5.w%0d", i / 2), stream[i-1], stream[i], 1'b1);
      end else begin
        chk($sformatf("t5.gap%0d", i / 2), 32'(out_valid), 32'd0);
      end
    end
    in_valid = 1'b0;
    tick();
    chk("t5.end", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

`ifdef DEMUX_PARITY_EN
    chk("t6.par_idle", 32'(par_err), 32'd0);
    in_valid = 1'b1;
    din = 8'h03; in_par = 1'b0;
    tick();
    din = 8'h01; in_par = 1'b0;
    tick();
    chk("t6.bad_ov", 32'(out_valid), 32'd1);
    chk("t6.bad_err", 32'(par_err), 32'd1);
    out_ready = 1'b1;
    din = 8'h03; in_par = 1'b0;
    tick();
    chk("t6.err_hidden", 32'(par_err), 32'd0);
    out_ready = 1'b0;
    din = 8'h05; in_par = 1'b0;
    tick();
    chk("t6.good_ov", 32'(out_valid), 32'd1);
    chk("t6.good_err", 32'(par_err), 32'd0);
    in_valid = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
